// File: rtl/mac3_drain.sv
`default_nettype none
// ============================================================================
// Module      : mac3_drain
// Description : Output stage behind the 3-way pipelined MAC. Tracks which
//               issued operations close an output pixel, captures the MAC
//               accumulator when that result emerges, rounds/scales/saturates
//               it, buffers it in a small FIFO and drains it to the output
//               memory writer with sequential addresses and a frame-done pulse.
// Ports       : clk, rst_in       - clock, synchronous active-high reset
//               input_valid       - MAC pipeline advance strobe
//               last_in           - issue is final accumulation of an output
//               acc_in            - MAC accumulator register (signed)
//               issue_ready_out   - credit: upstream may issue last_in=1
//               out_valid/ready   - result handshake to memory writer
//               out_data/out_addr - result word and its write address
//               frame_done        - pulse after the last address of a frame
//               sat_count         - sticky-at-max count of clamped results
//               overflow_err      - sticky protocol violation flag
//               busy              - results in flight or buffered
// Revision    : 1.0 - initial release
// ============================================================================
module mac3_drain #(
    parameter int ACCUMULATOR_WIDTH = 32,
    parameter int OUTPUT_WIDTH      = 16,
    parameter int OUTPUT_SCALE      = 0,
    parameter int PIPE_DEPTH        = 4,
    parameter int FIFO_DEPTH        = 4,
    parameter int NUM_OUTPUTS       = 64,
    parameter int SAT_CNT_WIDTH     = 16
) (
    input  logic                                clk,
    input  logic                                rst_in,
    input  logic                                input_valid,
    input  logic                                last_in,
    input  logic signed [ACCUMULATOR_WIDTH-1:0] acc_in,
    output logic                                issue_ready_out,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [OUTPUT_WIDTH-1:0]      out_data,
    output logic [$clog2(NUM_OUTPUTS)-1:0]      out_addr,
    output logic                                frame_done,
    output logic [SAT_CNT_WIDTH-1:0]            sat_count,
    output logic                                overflow_err,
    output logic                                busy
);

    localparam int TAG_W  = PIPE_DEPTH - 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W  = $clog2(PIPE_DEPTH + 1);
    localparam int SUM_W  = CNT_W + INF_W;
    localparam int EXT_W  = ACCUMULATOR_WIDTH + 1;
    localparam int ADDR_W = $clog2(NUM_OUTPUTS);

    localparam logic [ADDR_W-1:0]        ADDR_LAST = ADDR_W'(NUM_OUTPUTS - 1);
    localparam logic [CNT_W-1:0]         FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [SUM_W-1:0]         CREDITS   = SUM_W'(FIFO_DEPTH);
    localparam logic [SAT_CNT_WIDTH-1:0] SAT_MAX   = '1;
    localparam logic signed [EXT_W-1:0]  OUT_MAX   =
        EXT_W'((64'sd1 <<< (OUTPUT_WIDTH - 1)) - 64'sd1);
    // Two's complement: -(max) - 1 == ~max
    localparam logic signed [EXT_W-1:0]  OUT_MIN   = ~OUT_MAX;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]              tag_q, tag_d;
    logic                          push_pending_q;
    logic signed [OUTPUT_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]              count_q, count_d;
    logic [ADDR_W-1:0]             out_addr_q;
    logic                          frame_done_q;
    logic [SAT_CNT_WIDTH-1:0]      sat_count_q;
    logic                          overflow_q;

    // ------------------------------------------------------------------
    // Tag shift register: one bit per in-flight issue, advanced only by
    // the same strobe that advances the MAC pipeline.
    // ------------------------------------------------------------------
    always_comb begin
        tag_d = tag_q;
        if (input_valid) begin
            tag_d    = tag_q << 1;
            tag_d[0] = last_in;
        end
    end

    // ------------------------------------------------------------------
    // Credits: every tagged issue and the pending capture will each
    // claim one FIFO slot, so they are reserved up front.
    // ------------------------------------------------------------------
    logic [INF_W-1:0] w_inflight;

    always_comb begin
        w_inflight = INF_W'(push_pending_q);
        for (int i = 0; i < TAG_W; i++) begin
            w_inflight = w_inflight + INF_W'(tag_q[i]);
        end
    end

    assign issue_ready_out = (SUM_W'(count_q) + SUM_W'(w_inflight)) < CREDITS;
    assign busy            = (w_inflight != '0) || (count_q != '0);

    // ------------------------------------------------------------------
    // Conversion: round half up, arithmetic shift, saturate. The extra
    // top bit keeps the rounding add from wrapping at the positive end.
    // ------------------------------------------------------------------
    logic signed [EXT_W-1:0]        w_acc_ext;
    logic signed [EXT_W-1:0]        w_scaled;
    logic                           w_sat_hi, w_sat_lo;
    logic signed [OUTPUT_WIDTH-1:0] w_result;

    assign w_acc_ext = {acc_in[ACCUMULATOR_WIDTH-1], acc_in};

    generate
        if (OUTPUT_SCALE > 0) begin : g_round
            localparam logic signed [EXT_W-1:0] HALF_LSB =
                EXT_W'(1) << (OUTPUT_SCALE - 1);
            assign w_scaled = (w_acc_ext + HALF_LSB) >>> OUTPUT_SCALE;
        end else begin : g_no_round
            assign w_scaled = w_acc_ext;
        end
    endgenerate

    assign w_sat_hi = w_scaled > OUT_MAX;
    assign w_sat_lo = w_scaled < OUT_MIN;

    always_comb begin
        w_result = w_scaled[OUTPUT_WIDTH-1:0];
        if (w_sat_hi) begin
            w_result = OUT_MAX[OUTPUT_WIDTH-1:0];
        end else if (w_sat_lo) begin
            w_result = OUT_MIN[OUTPUT_WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FIFO control. A pop frees the slot a same-cycle push needs, so a
    // full FIFO only drops when nothing leaves that cycle.
    // ------------------------------------------------------------------
    logic w_pop, w_full, w_push, w_drop, w_bad_issue;

    assign w_pop       = out_valid & out_ready;
    assign w_full      = (count_q == FIFO_FULL);
    assign w_push      = push_pending_q & (~w_full | w_pop);
    assign w_drop      = push_pending_q & w_full & ~w_pop;
    assign w_bad_issue = input_valid & last_in & ~issue_ready_out;

    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            tag_q          <= '0;
            push_pending_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            out_addr_q     <= '0;
            frame_done_q   <= 1'b0;
            sat_count_q    <= '0;
            overflow_q     <= 1'b0;
        end else begin
            tag_q          <= tag_d;
            push_pending_q <= input_valid & tag_q[TAG_W-1];
            count_q        <= count_d;
            frame_done_q   <= w_pop & (out_addr_q == ADDR_LAST);
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                out_addr_q <= (out_addr_q == ADDR_LAST) ? '0 : out_addr_q + ADDR_W'(1);
            end
            if (push_pending_q && (w_sat_hi || w_sat_lo) && (sat_count_q != SAT_MAX)) begin
                sat_count_q <= sat_count_q + SAT_CNT_WIDTH'(1);
            end
            if (w_bad_issue || w_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= w_result;
        end
    end

    assign out_valid    = (count_q != '0);
    assign out_data     = fifo_mem_q[rd_ptr_q];
    assign out_addr     = out_addr_q;
    assign frame_done   = frame_done_q;
    assign sat_count    = sat_count_q;
    assign overflow_err = overflow_q;

endmodule
`default_nettype wire
